// File: rtl/mac_pkg.sv
// Shared definitions for the MAC tile sequencer: dimension limits, FSM states, MNT field access.
`timescale 1ns/1ps
package mac_pkg;

  localparam int unsigned DIM_MAX = 8;
  localparam int unsigned TILE    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_WRITE,
    S_FIN,
    S_ERR
  } state_t;

  function automatic logic [3:0] mnt_m(input logic [11:0] v);
    return v[11:8];
  endfunction

  function automatic logic [3:0] mnt_n(input logic [11:0] v);
    return v[7:4];
  endfunction

  function automatic logic [3:0] mnt_t(input logic [11:0] v);
    return v[3:0];
  endfunction

  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(DIM_MAX));
  endfunction

endpackage

// File: rtl/mac_slot_cnt.sv
// 2-bit slot counter k with terminal-count flag, shared by the LOAD, STREAM and WRITE phases.
`timescale 1ns/1ps
module mac_slot_cnt (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [1:0] o_k,
  output logic       o_tc
);

  logic [1:0] r_k;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      r_k <= '0;
    else if (i_clr) r_k <= '0;
    else if (i_en)  r_k <= r_k + 2'd1;
  end

  assign o_k  = r_k;
  assign o_tc = (r_k == 2'd3);

endmodule

// File: rtl/mac_tile_sched.sv
// Job sequencer for the 4x4 MAC array: tiles O = I * W^T, drives buffer reads/writes and datapath strobes.
// Optional build macro PERF_CNT_EN adds the CYC_CNT busy-cycle counter port.
`timescale 1ns/1ps
module mac_tile_sched #(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [11:0] MNT,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        EN_I,
  output logic [2:0]  ADDR_I,
  output logic        EN_W,
  output logic [2:0]  ADDR_W,
  output logic        EN_O,
  output logic        RW_O,
  output logic [3:0]  ADDR_O,
  output logic [63:0] WDATA_O,
  output logic [3:0]  DP_KLEN,
  output logic        DP_W_LD,
  output logic        DP_W_ZERO,
  output logic        DP_I_VLD,
  output logic        DP_ACC_CLR,
  output logic [1:0]  DP_IDX,
  output logic [1:0]  DP_RSEL,
`ifdef PERF_CNT_EN
  output logic [15:0] CYC_CNT,
`endif
  input  logic [63:0] DP_RESULT
);

  import mac_pkg::*;

  localparam int unsigned DW = $clog2(PIPE_LAT + 2);

  state_t         r_state, w_next;
  logic [3:0]     r_m, r_n, r_t, r_klen;
  logic           r_tr, r_tc;
  logic [DW-1:0]  r_drain;
  logic           r_w_ld, r_w_zero, r_i_vld;
  logic [1:0]     r_idx;
  logic [1:0]     w_k;
  logic           w_k_tc;
  logic [2:0]     w_wrow, w_irow;
  logic           w_w_in, w_i_in, w_legal, w_last_r, w_last_c, w_last;

  mac_slot_cnt u_slot (
    .CLK  (CLK),
    .RSTN (RSTN),
    .i_clr(r_state == S_IDLE),
    .i_en ((r_state == S_LOAD) || (r_state == S_STREAM) || (r_state == S_WRITE)),
    .o_k  (w_k),
    .o_tc (w_k_tc)
  );

  assign w_wrow   = {r_tc, w_k};
  assign w_irow   = {r_tr, w_k};
  assign w_w_in   = {1'b0, w_wrow} < r_m;
  assign w_i_in   = {1'b0, w_irow} < r_t;
  assign w_legal  = dim_ok(r_m) && dim_ok(r_n) && dim_ok(r_t);
  // Tile (tr,tc) is the last in its row/column when 4*(idx+1) reaches the dimension.
  assign w_last_r = (r_tr ? 4'd8 : 4'd4) >= r_t;
  assign w_last_c = (r_tc ? 4'd8 : 4'd4) >= r_m;
  assign w_last   = w_last_r && w_last_c;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (START) w_next = S_CHECK;
      S_CHECK:  w_next = w_legal ? S_LOAD : S_ERR;
      S_LOAD:   if (w_k_tc) w_next = S_STREAM;
      S_STREAM: if (w_k_tc) w_next = S_DRAIN;
      S_DRAIN:  if (r_drain == '0) w_next = S_WRITE;
      S_WRITE:  if (w_k_tc) w_next = w_last ? S_FIN : S_LOAD;
      S_FIN:    w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_m      <= '0;
      r_n      <= '0;
      r_t      <= '0;
      r_klen   <= '0;
      r_tr     <= 1'b0;
      r_tc     <= 1'b0;
      r_drain  <= '0;
      r_w_ld   <= 1'b0;
      r_w_zero <= 1'b0;
      r_i_vld  <= 1'b0;
      r_idx    <= '0;
    end else begin
      if (r_state == S_IDLE && START) begin
        r_m <= mnt_m(MNT);
        r_n <= mnt_n(MNT);
        r_t <= mnt_t(MNT);
      end
      if (r_state == S_CHECK && w_legal) begin
        r_klen <= r_n;
        r_tr   <= 1'b0;
        r_tc   <= 1'b0;
      end
      if (r_state == S_STREAM && w_k_tc) r_drain <= DW'(PIPE_LAT);
      else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - DW'(1);
      if (r_state == S_WRITE && w_k_tc && !w_last) begin
        if (w_last_c) begin
          r_tc <= 1'b0;
          r_tr <= ~r_tr;
        end else begin
          r_tc <= 1'b1;
        end
      end
      // Buffer reads return one cycle later, so datapath strobes are the issue slots delayed by one.
      r_w_ld   <= (r_state == S_LOAD);
      r_w_zero <= (r_state == S_LOAD) && !w_w_in;
      r_i_vld  <= (r_state == S_STREAM) && w_i_in;
      r_idx    <= ((r_state == S_LOAD) || (r_state == S_STREAM)) ? w_k : 2'd0;
    end
  end

  always_comb begin
    BUSY       = (r_state != S_IDLE);
    DONE       = 1'b0;
    ERR        = 1'b0;
    EN_I       = 1'b0;
    ADDR_I     = '0;
    EN_W       = 1'b0;
    ADDR_W     = '0;
    EN_O       = 1'b0;
    RW_O       = 1'b0;
    ADDR_O     = '0;
    DP_ACC_CLR = 1'b0;
    DP_RSEL    = '0;
    case (r_state)
      S_LOAD: begin
        DP_ACC_CLR = (w_k == 2'd0);
        EN_W       = w_w_in;
        ADDR_W     = w_w_in ? w_wrow : 3'd0;
      end
      S_STREAM: begin
        EN_I   = w_i_in;
        ADDR_I = w_i_in ? w_irow : 3'd0;
      end
      S_WRITE: begin
        DP_RSEL = w_k;
        EN_O    = w_i_in;
        RW_O    = w_i_in;
        ADDR_O  = w_i_in ? {w_irow, r_tc} : 4'd0;
      end
      S_FIN:   DONE = 1'b1;
      S_ERR:   ERR  = 1'b1;
      default: ;
    endcase
  end

  assign WDATA_O   = DP_RESULT;
  assign DP_KLEN   = r_klen;
  assign DP_W_LD   = r_w_ld;
  assign DP_W_ZERO = r_w_zero;
  assign DP_I_VLD  = r_i_vld;
  assign DP_IDX    = r_idx;

`ifdef PERF_CNT_EN
  logic [15:0] r_cyc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                r_cyc <= '0;
    else if (r_state == S_IDLE && START)      r_cyc <= '0;
    else if (r_state != S_IDLE && r_cyc != '1) r_cyc <= r_cyc + 16'd1;
  end

  assign CYC_CNT = r_cyc;
`endif

endmodule
